// File: rtl/display_pkg.sv
// Shared types and glyph constants for the 4-digit multiplexed 7-segment display.
// Segment vectors are active low, bit 0 = segment a, bit 6 = segment g.
package display_pkg;

  typedef logic [6:0] seg_t;
  typedef logic [1:0] indice_digito_t;

  localparam seg_t SEG_APAGADO = 7'h7F;
  localparam seg_t SEG_GUION   = 7'h3F;

  localparam seg_t SEG_0 = 7'h40;
  localparam seg_t SEG_1 = 7'h79;
  localparam seg_t SEG_2 = 7'h24;
  localparam seg_t SEG_3 = 7'h30;
  localparam seg_t SEG_4 = 7'h19;
  localparam seg_t SEG_5 = 7'h12;
  localparam seg_t SEG_6 = 7'h02;
  localparam seg_t SEG_7 = 7'h78;
  localparam seg_t SEG_8 = 7'h00;
  localparam seg_t SEG_9 = 7'h10;
  localparam seg_t SEG_A = 7'h08;
  localparam seg_t SEG_B = 7'h03;
  localparam seg_t SEG_C = 7'h46;
  localparam seg_t SEG_D = 7'h21;
  localparam seg_t SEG_E = 7'h06;
  localparam seg_t SEG_F = 7'h0E;

  // Decoder code space: 0..15 hex glyphs, 16 dash, anything else blank.
  localparam logic [4:0] COD_GUION = 5'd16;

  // Error class shown on digit 2; the encoding is the glyph value itself.
  typedef enum logic [1:0] {
    CLASE_OK     = 2'd0,
    CLASE_SIMPLE = 2'd1,
    CLASE_DOBLE  = 2'd2
  } clase_error_t;

  // Snapshot of the decoder outputs taken once per refresh frame.
  typedef struct packed {
    logic [3:0] tx;
    logic [3:0] corr;
    logic [2:0] sind;
    logic       err;
  } captura_t;

endpackage

// File: rtl/decodificador_7seg.sv
// Combinational 5-bit code to active-low 7-segment glyph (hex, dash, blank).
module decodificador_7seg
  import display_pkg::*;
(
  input  logic [4:0] i_codigo,
  output seg_t       o_seg
);

  // Code lookup: hex glyphs first, then dash, everything else dark.
  always_comb begin
    o_seg = SEG_APAGADO;
    case (i_codigo)
      5'd0:      o_seg = SEG_0;
      5'd1:      o_seg = SEG_1;
      5'd2:      o_seg = SEG_2;
      5'd3:      o_seg = SEG_3;
      5'd4:      o_seg = SEG_4;
      5'd5:      o_seg = SEG_5;
      5'd6:      o_seg = SEG_6;
      5'd7:      o_seg = SEG_7;
      5'd8:      o_seg = SEG_8;
      5'd9:      o_seg = SEG_9;
      5'd10:     o_seg = SEG_A;
      5'd11:     o_seg = SEG_B;
      5'd12:     o_seg = SEG_C;
      5'd13:     o_seg = SEG_D;
      5'd14:     o_seg = SEG_E;
      5'd15:     o_seg = SEG_F;
      COD_GUION: o_seg = SEG_GUION;
      default:   o_seg = SEG_APAGADO;
    endcase
  end

endmodule

// File: rtl/modulo_display_7seg.sv
// 4-digit common-anode multiplexed display for the Hamming SECDED decoder.
// Digits (right to left): corrected nibble, syndrome, error class, tx nibble.
// Inputs are captured once per frame; outputs are registered (1-cycle latency).
// Optional feature: define PARPADEO_EN to blink the display on a double error.
module modulo_display_7seg
  import display_pkg::*;
#(
  parameter int unsigned CICLOS_DIGITO   = 27_000,
  parameter int unsigned CICLOS_PARPADEO = 6_750_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] palabra_tx,
  input  logic [3:0] palabra_corr,
  input  logic [2:0] sindrome,
  input  logic       error_doble,
  output logic [3:0] anodo,
  output logic [6:0] segmentos
);

  localparam int unsigned CW = (CICLOS_DIGITO > 1) ? $clog2(CICLOS_DIGITO) : 1;
  localparam logic [CW-1:0] CONT_MAX = CW'(CICLOS_DIGITO - 1);

  logic [CW-1:0]  r_cont;
  indice_digito_t r_indice;
  captura_t       r_cap;
  logic           r_primera;
  logic [3:0]     r_anodo;
  seg_t           r_seg;

  logic           w_fin_digito;
  logic           w_fin_marco;
  logic           w_cargar;
  clase_error_t   w_clase;
  logic [4:0]     w_codigo;
  seg_t           w_seg;
  logic [3:0]     w_anodo_sig;

  assign w_fin_digito = (r_cont == CONT_MAX);
  assign w_fin_marco  = w_fin_digito && (r_indice == 2'd3);
  assign w_cargar     = r_primera || w_fin_marco;

  // Per-digit cycle counter and digit index; index advances on each wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cont   <= '0;
      r_indice <= '0;
    end else if (w_fin_digito) begin
      r_cont   <= '0;
      r_indice <= r_indice + 2'd1;
    end else begin
      r_cont   <= r_cont + 1'b1;
    end
  end

  // Input capture: first edge after reset, then only at frame end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cap     <= '0;
      r_primera <= 1'b1;
    end else begin
      r_primera <= 1'b0;
      if (w_cargar) begin
        r_cap <= '{tx: palabra_tx, corr: palabra_corr, sind: sindrome, err: error_doble};
      end
    end
  end

  // Error class derived from the captured syndrome and double-error flag.
  always_comb begin
    w_clase = CLASE_OK;
    if (r_cap.err)
      w_clase = CLASE_DOBLE;
    else if (r_cap.sind != 3'd0)
      w_clase = CLASE_SIMPLE;
  end

  // Glyph code for the digit currently being scanned.
  always_comb begin
    w_codigo = '0;
    case (r_indice)
      2'd0:    w_codigo = {1'b0, r_cap.corr};
      2'd1:    w_codigo = r_cap.err ? COD_GUION : {2'b00, r_cap.sind};
      2'd2:    w_codigo = {3'b000, w_clase};
      default: w_codigo = {1'b0, r_cap.tx};
    endcase
  end

  decodificador_7seg u_decodificador (
    .i_codigo (w_codigo),
    .o_seg    (w_seg)
  );

`ifdef PARPADEO_EN
  localparam int unsigned PW = (CICLOS_PARPADEO > 1) ? $clog2(CICLOS_PARPADEO) : 1;
  localparam logic [PW-1:0] PARP_MAX = PW'(CICLOS_PARPADEO - 1);

  logic [PW-1:0] r_parp;
  logic          r_fase;

  // Blink phase generator, parked at phase 0 while no double error is captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_parp <= '0;
      r_fase <= 1'b0;
    end else if (!r_cap.err) begin
      r_parp <= '0;
      r_fase <= 1'b0;
    end else if (r_parp == PARP_MAX) begin
      r_parp <= '0;
      r_fase <= ~r_fase;
    end else begin
      r_parp <= r_parp + 1'b1;
    end
  end
`endif

  // Next anode pattern: blank slot at cont 0, otherwise one-hot active-low digit.
  always_comb begin
    w_anodo_sig = ~(4'b0001 << r_indice);
    if (r_cont == '0)
      w_anodo_sig = '1;
`ifdef PARPADEO_EN
    if (r_cap.err && r_fase)
      w_anodo_sig = '1;
`endif
  end

  // Output registers; async reset blanks the display immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_anodo <= '1;
      r_seg   <= SEG_APAGADO;
    end else begin
      r_anodo <= w_anodo_sig;
      r_seg   <= w_seg;
    end
  end

  assign anodo     = r_anodo;
  assign segmentos = r_seg;

endmodule

// File: tb/tb_modulo_display_7seg.sv
// Self-checking bench for modulo_display_7seg (default build, blink disabled).
module tb_modulo_display_7seg;

  localparam int unsigned CD = 4;
  localparam int unsigned CP = 16;
  localparam int FRAME = 4 * CD;

  logic       clk;
  logic       rst_n;
  logic [3:0] palabra_tx;
  logic [3:0] palabra_corr;
  logic [2:0] sindrome;
  logic       error_doble;
  logic [3:0] anodo;
  logic [6:0] segmentos;

  modulo_display_7seg #(
    .CICLOS_DIGITO   (CD),
    .CICLOS_PARPADEO (CP)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .palabra_tx   (palabra_tx),
    .palabra_corr (palabra_corr),
    .sindrome     (sindrome),
    .error_doble  (error_doble),
    .anodo        (anodo),
    .segmentos    (segmentos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]      tx;
    logic [3:0]      corr;
    logic [2:0]      sind;
    logic            err;
    logic [3:0][6:0] d;
  } vec_t;

  int unsigned total;
  int unsigned bad;
  int          edges;

  function automatic vec_t mk(logic [3:0] tx, logic [3:0] corr, logic [2:0] sind, logic err,
                              logic [6:0] d0, logic [6:0] d1, logic [6:0] d2, logic [6:0] d3);
    vec_t v;
    v.tx = tx; v.corr = corr; v.sind = sind; v.err = err;
    v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
    return v;
  endfunction

  task automatic check(string nm, logic [6:0] act, logic [6:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%b want=%b", nm, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    edges++;
  endtask

  task automatic apply(vec_t v);
    palabra_tx   = v.tx;
    palabra_corr = v.corr;
    sindrome     = v.sind;
    error_doble  = v.err;
  endtask

  // Check one output sample against the frame position it belongs to.
  task automatic check_sample(string nm, logic [3:0][6:0] d);
    int pos, c, ix;
    logic [3:0] ea;
    pos = (edges - 1) % FRAME;
    c   = pos % CD;
    ix  = pos / CD;
    ea  = (c == 0) ? 4'b1111 : ~(4'b0001 << ix);
    check({nm, "_anodo"}, {3'b000, anodo}, {3'b000, ea});
    if (c != 0)
      check({nm, "_seg"}, segmentos, d[ix]);
  endtask

  // Called right after a capture edge; checks the whole following frame.
  task automatic check_frame(string nm, logic [3:0][6:0] d);
    for (int k = 0; k < FRAME; k++) begin
      tick();
      check_sample(nm, d);
    end
  endtask

  // Advance to the next capture edge (bounded by one frame).
  task automatic sync();
    tick();
    while (edges % FRAME != 0) tick();
  endtask

  vec_t tabla[6];
  logic [3:0][6:0] d_old;
  logic [3:0][6:0] d_new;
  logic [3:0][6:0] d_cero;

  initial begin
    total = 0; bad = 0; edges = 0;
    tabla[0] = mk(4'hC, 4'hC, 3'd0, 1'b0, 7'h46, 7'h40, 7'h40, 7'h46);
    tabla[1] = mk(4'hC, 4'hC, 3'd5, 1'b0, 7'h46, 7'h12, 7'h79, 7'h46);
    tabla[2] = mk(4'h9, 4'h9, 3'd3, 1'b1, 7'h10, 7'h3F, 7'h24, 7'h10);
    tabla[3] = mk(4'hF, 4'hE, 3'd7, 1'b0, 7'h06, 7'h78, 7'h79, 7'h0E);
    tabla[4] = mk(4'h0, 4'hD, 3'd0, 1'b0, 7'h21, 7'h40, 7'h40, 7'h40);
    tabla[5] = mk(4'hB, 4'hA, 3'd2, 1'b0, 7'h08, 7'h24, 7'h79, 7'h03);
    d_cero = {7'h40, 7'h40, 7'h40, 7'h40};

    // Reset held 3 cycles: display dark.
    rst_n = 1'b0;
    palabra_tx = '0; palabra_corr = '0; sindrome = '0; error_doble = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("reset_anodo", {3'b000, anodo}, 7'b0001111);
      check("reset_seg", segmentos, 7'h7F);
    end
    @(negedge clk);
    rst_n = 1'b1;
    edges = 0;
    check_frame("post_reset", d_cero);

    // Table vectors: each shows up in full on the frame after its capture.
    for (int i = 0; i < 6; i++) begin
      apply(tabla[i]);
      sync();
      check_frame($sformatf("vec%0d", i), tabla[i].d);
    end

    // Mid-frame change: current frame keeps old snapshot, next frame shows new.
    apply(tabla[0]);
    sync();
    check_frame("mid_pre", tabla[0].d);
    d_old = tabla[0].d;
    d_new = {7'h30, 7'h79, 7'h02, 7'h30};
    for (int k = 0; k < CD + 1; k++) begin
      tick();
      check_sample("mid_old", d_old);
    end
    palabra_tx = 4'h3; palabra_corr = 4'h3; sindrome = 3'd6; error_doble = 1'b0;
    while (edges % FRAME != 0) begin
      tick();
      check_sample("mid_hold", d_old);
    end
    check_frame("mid_new", d_new);

    // Reset while digit 2 is scanned: blanks without a clock edge.
    for (int k = 0; k < FRAME && !(((edges - 1) % FRAME) / CD == 2 && ((edges - 1) % CD) == 1); k++)
      tick();
    check("pre_rst_anodo", {3'b000, anodo}, 7'b0001011);
    rst_n = 1'b0;
    #1;
    check("async_rst_anodo", {3'b000, anodo}, 7'b0001111);
    check("async_rst_seg", segmentos, 7'h7F);
    repeat (3) @(posedge clk);
    #1;
    check("rst_hold_anodo", {3'b000, anodo}, 7'b0001111);
    @(negedge clk);
    rst_n = 1'b1;
    edges = 0;
    check_frame("restart", d_new);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/modulo_display_7seg.md
# modulo_display_7seg

Downstream stage of the Hamming SECDED decoder. Drives a 4-digit, common-anode, time-multiplexed 7-segment display with the transmitted nibble, the corrected nibble, the error position and the error class. Inputs are captured once per refresh frame, so a digit never shows a mix of old and new values.

## Interface
- `CICLOS_DIGITO`, default 27_000: clock cycles each digit is active (1 kHz per digit at 27 MHz). Legal values are ≥ 2.
- `CICLOS_PARPADEO`, default 6_750_000: half-period of the blink, in cycles. Used only with `PARPADEO_EN`.
- `clk` in, 1 bit: system clock. The block uses this single clock.
- `rst_n` in, 1 bit: asynchronous, active-low reset.
- `palabra_tx` in, 4 bits: transmitted nibble.
- `palabra_corr` in, 4 bits: corrected nibble from the decoder.
- `sindrome` in, 3 bits: error position from the decoder. 0 means no single-bit error.
- `error_doble` in, 1 bit: the decoder has detected a double error.
- `anodo` out, 4 bits: digit enables, active low. `anodo[0]` is the rightmost digit.
- `segmentos` out, 7 bits: segments a–g, active low. `segmentos[0]` = a, `segmentos[6]` = g.

## Operation
- **Counters.**
  - `cont` counts 0..CICLOS_DIGITO-1 and wraps.
  - `indice` (2 bits) increments on each `cont` wrap, 3→0.
- **Capture.** A capture register holds {`palabra_tx`, `palabra_corr`, `sindrome`, `error_doble`}.
  - It loads on the first clock edge after reset release.
  - After that, it loads on the edge where `cont`==CICLOS_DIGITO-1 and `indice`==3 (frame end).
  - Input changes at any other time are not visible until the next frame.
- **Digit contents** (all taken from the captured values):
  - Digit 0: `palabra_corr` in hex (0–F).
  - Digit 1: `sindrome` in hex (0–7). Shows '-' (g only) if `error_doble`.
  - Digit 2: class.
    - '0' if `sindrome`==0 and not `error_doble`.
    - '1' if `sindrome`≠0 and not `error_doble`.
    - '2' if `error_doble`.
  - Digit 3: `palabra_tx` in hex.
- **Blanking.** In the cycle where `cont`==0, `anodo`=4'b1111 (anti-ghosting slot).
  - In all other cycles, `anodo`=~(4'b0001<<`indice`).
- **Output registers.** `segmentos` and `anodo` are registered. No combinational path from any input to any output.
- **Reset.**
  - `anodo`=4'b1111, `segmentos`=7'b1111111.
  - `cont`=0, `indice`=0, capture register all zeros.
  - Asserting reset mid-frame blanks the display immediately, without waiting for a clock edge.

## Timing
- **Outputs.** `anodo`/`segmentos` in cycle n+1 reflect `cont`/`indice`/capture register at cycle n. The latency is exactly 1 cycle.
- **Frame.** One frame is 4×CICLOS_DIGITO cycles.
- **Input to display.**
  - Worst-case latency from an input change to its display is 2 frames + 1 cycle.
  - An input change coinciding with the capture edge is sampled on that edge.
- **Simultaneous events.**
  - A `cont` wrap and a capture are simultaneous.
  - Segments for the new frame's digit 0 use the new capture.
- **Counter widths.** `$clog2(CICLOS_DIGITO)` and `$clog2(CICLOS_PARPADEO)`. No overflow beyond the terminal value.

## Configuration
- **`PARPADEO_EN` defined:**
  - A blink counter toggles a phase bit every CICLOS_PARPADEO cycles.
  - While the captured `error_doble`=1 and phase=1, `anodo`=4'b1111 for the whole phase. The cycle counters keep running.
  - The blink counter resets to 0, with phase 0.
  - When `error_doble` is 0, the counter is held at 0.
- **`PARPADEO_EN` undefined:** no blink logic is present, and a double error is shown steadily.

## Structure
- **Package `display_pkg`:**
  - `typedef logic [6:0] seg_t`.
  - Constants `SEG_APAGADO`=7'h7F and `SEG_GUION`=7'h3F.
  - Hex glyph constants 0–F (active low).
  - `typedef logic [1:0] indice_digito_t`.
- **Sub-module `decodificador_7seg`:** combinational, 5-bit code → `seg_t`.
  - Codes 0–15 are hex glyphs.
  - Code 16 is '-'.
  - All other codes are blank.

## Test plan
Bench parameters: CICLOS_DIGITO=4, CICLOS_PARPADEO=16.

1. **Reset.** Hold `rst_n`=0 for 3 cycles → `anodo`=1111, `segmentos`=1111111.
   - On release, the first active digit 0 shows '0' (7'b1000000).
2. **No error.** `palabra_tx`=4'hC, `palabra_corr`=4'hC, `sindrome`=0 → after capture, the digits right to left show C, 0, 0, C.
   - `anodo` sequence per frame: 1111, 1110×3, 1111, 1101×3, …
3. **Single error.** `palabra_corr`=4'hC, `sindrome`=3'd5 → digit 1 shows '5' (7'b0010010) and digit 2 shows '1' (7'b1111001).
4. **Double error.** `error_doble`=1 → digit 1 shows '-' (7'b0111111) and digit 2 shows '2' (7'b0100100).
   - With `PARPADEO_EN`: `anodo`=1111 for 16 cycles, then scans for 16 cycles, alternating.
5. **Mid-frame input change.** Change `palabra_corr` from C to 3 while `indice`=1 → digit 0 keeps showing C until after the capture at the end of the frame (`indice`=3, `cont`=3).
6. **Reset mid-scan.** Drop `rst_n` when `indice`=2 → outputs blank with no clock edge. On release, scanning restarts at digit 0.
